// File: rtl/enemy_pkg.sv
// Shared constants, slot record and write-FSM states for the enemy pixel locator.
package enemy_pkg;

  localparam int N_SLOTS    = 6;
  localparam int E_SIZE     = 36;
  localparam int CW         = 10;
  localparam int ANGLE_BITS = 4;
  localparam int TYPE_BITS  = 4;

  typedef struct packed {
    logic [CW-1:0]         x;
    logic [CW-1:0]         y;
    logic [ANGLE_BITS-1:0] angle;
    logic [TYPE_BITS-1:0]  etype;
    logic                  active;
  } enemy_slot_t;

  typedef enum logic {
    ACCEPT = 1'b0,
    COMMIT = 1'b1
  } wr_state_t;

endpackage

// File: rtl/enemy_bbox_hit.sv
// Combinational bounding-box test for one enemy slot: hit flag plus sprite-local coordinates.
module enemy_bbox_hit
  import enemy_pkg::*;
(
  input  logic [CW-1:0] hc,
  input  logic [CW-1:0] vc,
  input  enemy_slot_t   slot,
  output logic          hit,
  output logic [CW-1:0] loc_hc,
  output logic [CW-1:0] loc_vc
);

  localparam logic [CW-1:0] EDGE = CW'(E_SIZE);

  logic signed [CW:0] dx;
  logic signed [CW:0] dy;
  logic               in_x;
  logic               in_y;

  // One extra bit keeps the difference signed, so a sprite near the right or
  // bottom edge never wraps around into column/row 0.
  assign dx = $signed({1'b0, hc}) - $signed({1'b0, slot.x});
  assign dy = $signed({1'b0, vc}) - $signed({1'b0, slot.y});

  assign in_x = !dx[CW] && (dx[CW-1:0] < EDGE);
  assign in_y = !dy[CW] && (dy[CW-1:0] < EDGE);
  assign hit  = slot.active && in_x && in_y;

  assign loc_hc = hit ? dx[CW-1:0] : '0;
  assign loc_vc = hit ? dy[CW-1:0] : '0;

endmodule

// File: rtl/enemy_pixel_locator.sv
// Enemy slot table with frame-start commit and a 2-stage per-pixel hit pipeline.
// Define ENEMY_COMMIT_IMMEDIATE_EN to drop the shadow table and write the live table directly.
module enemy_pixel_locator
  import enemy_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [CW-1:0]              hc,
  input  logic [CW-1:0]              vc,
  input  logic                       pix_valid,
  input  logic                       frame_start,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [2:0]                 wr_slot,
  input  logic [CW-1:0]              wr_x,
  input  logic [CW-1:0]              wr_y,
  input  logic [ANGLE_BITS-1:0]      wr_angle,
  input  logic [TYPE_BITS-1:0]       wr_type,
  input  logic                       wr_active,
  output logic                       out_valid,
  output logic [N_SLOTS-1:0]         in_pixel,
  output logic [N_SLOTS-1:0]         active,
  output logic [N_SLOTS*CW-1:0]      loc_hc,
  output logic [N_SLOTS*CW-1:0]      loc_vc,
  output logic [N_SLOTS*ANGLE_BITS-1:0] angle,
  output logic [N_SLOTS*TYPE_BITS-1:0]  etype
);

  wr_state_t   state, state_next;
  logic        ready_next;
  logic        wr_fire;
  enemy_slot_t wr_entry;
  enemy_slot_t live [N_SLOTS];

  assign wr_fire  = wr_valid && wr_ready;
  assign wr_entry = '{x: wr_x, y: wr_y, angle: wr_angle, etype: wr_type, active: wr_active};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ACCEPT;
      wr_ready <= 1'b0;
    end else begin
      state    <= state_next;
      wr_ready <= ready_next;
    end
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
`ifdef ENEMY_COMMIT_IMMEDIATE_EN
    state_next = ACCEPT;
`else
    case (state)
      ACCEPT:  if (frame_start) state_next = COMMIT;
      COMMIT:  state_next = ACCEPT;
      default: state_next = ACCEPT;
    endcase
`endif
    ready_next = (state_next == ACCEPT);
  end

`ifndef ENEMY_COMMIT_IMMEDIATE_EN
  enemy_slot_t shadow [N_SLOTS];
`endif

  // NOTE: the tables are small flop arrays whose cleared state is observable, so they take the reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        live[i] <= '0;
`ifndef ENEMY_COMMIT_IMMEDIATE_EN
        shadow[i] <= '0;
`endif
      end
    end else begin
`ifdef ENEMY_COMMIT_IMMEDIATE_EN
      for (int i = 0; i < N_SLOTS; i++)
        if (wr_fire && wr_slot == 3'(i)) live[i] <= wr_entry;
`else
      // Slot numbers beyond the table match no entry and are dropped.
      for (int i = 0; i < N_SLOTS; i++)
        if (wr_fire && wr_slot == 3'(i)) shadow[i] <= wr_entry;
      if (state == COMMIT) live <= shadow;
`endif
    end
  end

  logic [CW-1:0] hc_q, vc_q;
  logic          valid_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hc_q    <= '0;
      vc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      hc_q    <= hc;
      vc_q    <= vc;
      valid_q <= pix_valid;
    end
  end

  logic [N_SLOTS-1:0] slot_hit;
  logic [CW-1:0]      slot_lhc [N_SLOTS];
  logic [CW-1:0]      slot_lvc [N_SLOTS];

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    enemy_bbox_hit u_bbox (
      .hc     (hc_q),
      .vc     (vc_q),
      .slot   (live[g]),
      .hit    (slot_hit[g]),
      .loc_hc (slot_lhc[g]),
      .loc_vc (slot_lvc[g])
    );
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid <= 1'b0;
      in_pixel  <= '0;
      active    <= '0;
      loc_hc    <= '0;
      loc_vc    <= '0;
      angle     <= '0;
      etype     <= '0;
    end else begin
      out_valid <= valid_q;
      in_pixel  <= valid_q ? slot_hit : '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        active[i]                         <= live[i].active;
        loc_hc[i*CW +: CW]                <= slot_lhc[i];
        loc_vc[i*CW +: CW]                <= slot_lvc[i];
        angle[i*ANGLE_BITS +: ANGLE_BITS] <= live[i].angle;
        etype[i*TYPE_BITS +: TYPE_BITS]   <= live[i].etype;
      end
    end
  end

endmodule

// File: tb/tb_enemy_pixel_locator.sv
// Self-checking bench: directed boundary cases plus random writes/commits/pixels against a table model.
module tb_enemy_pixel_locator;

`ifdef ENEMY_COMMIT_IMMEDIATE_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [9:0]  hc = '0, vc = '0;
  logic        pix_valid = 1'b0, frame_start = 1'b0, wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_slot = '0;
  logic [9:0]  wr_x = '0, wr_y = '0;
  logic [3:0]  wr_angle = '0, wr_type = '0;
  logic        wr_active = 1'b0;
  logic        out_valid;
  logic [5:0]  in_pixel, active;
  logic [59:0] loc_hc, loc_vc;
  logic [23:0] angle, etype;

  int checks = 0;
  int errors = 0;

  // Behavioural table model: plain integers per slot.
  int m_sx[6], m_sy[6], m_sa[6], m_st[6], m_sv[6];
  int m_lx[6], m_ly[6], m_la[6], m_lt[6], m_lv[6];

  enemy_pixel_locator dut (
    .CLK(CLK), .RST_N(RST_N), .hc(hc), .vc(vc), .pix_valid(pix_valid),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_slot(wr_slot), .wr_x(wr_x), .wr_y(wr_y), .wr_angle(wr_angle),
    .wr_type(wr_type), .wr_active(wr_active), .out_valid(out_valid),
    .in_pixel(in_pixel), .active(active), .loc_hc(loc_hc), .loc_vc(loc_vc),
    .angle(angle), .etype(etype)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      m_sx[i] = 0; m_sy[i] = 0; m_sa[i] = 0; m_st[i] = 0; m_sv[i] = 0;
      m_lx[i] = 0; m_ly[i] = 0; m_la[i] = 0; m_lt[i] = 0; m_lv[i] = 0;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 6; i++) begin
      m_lx[i] = m_sx[i]; m_ly[i] = m_sy[i]; m_la[i] = m_sa[i];
      m_lt[i] = m_st[i]; m_lv[i] = m_sv[i];
    end
  endtask

  task automatic do_write(input int slot, input int x, input int y, input int ang,
                          input int typ, input int act, input bit with_fs);
    bit accepted = 1'b0;
    wr_valid = 1'b1; wr_slot = slot[2:0]; wr_x = x[9:0]; wr_y = y[9:0];
    wr_angle = ang[3:0]; wr_type = typ[3:0]; wr_active = act[0];
    for (int n = 0; n < 8 && !accepted; n++) begin
      accepted = wr_ready;
      if (accepted && with_fs) frame_start = 1'b1;
      @(posedge CLK); #1;
    end
    wr_valid = 1'b0; frame_start = 1'b0;
    check("wr_handshake", 64'(accepted), 64'd1);
    if (accepted && slot < 6) begin
      if (IMM) begin
        m_lx[slot] = x; m_ly[slot] = y; m_la[slot] = ang; m_lt[slot] = typ; m_lv[slot] = act;
      end else begin
        m_sx[slot] = x; m_sy[slot] = y; m_sa[slot] = ang; m_st[slot] = typ; m_sv[slot] = act;
      end
    end
    if (accepted && with_fs) begin
      check("wr_fs_ready", 64'(wr_ready), 64'(IMM));
      @(posedge CLK); #1;
      if (!IMM) model_commit();
    end
  endtask

  task automatic do_commit();
    frame_start = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0;
    check("commit_ready_low", 64'(wr_ready), 64'(IMM));
    @(posedge CLK); #1;
    check("commit_ready_back", 64'(wr_ready), 64'd1);
    if (!IMM) model_commit();
  endtask

  task automatic check_outputs(input string tag, input int h, input int v, input bit valid);
    logic [5:0]  e_in, e_act;
    logic [59:0] e_lhc, e_lvc;
    logic [23:0] e_ang, e_typ;
    e_in = '0; e_act = '0; e_lhc = '0; e_lvc = '0; e_ang = '0; e_typ = '0;
    for (int i = 0; i < 6; i++) begin
      int dx, dy;
      bit h_i;
      dx = h - m_lx[i];
      dy = v - m_ly[i];
      h_i = (m_lv[i] != 0) && dx >= 0 && dx < 36 && dy >= 0 && dy < 36;
      e_in[i]  = valid && h_i;
      e_act[i] = (m_lv[i] != 0);
      if (h_i) begin
        e_lhc[i*10 +: 10] = dx[9:0];
        e_lvc[i*10 +: 10] = dy[9:0];
      end
      e_ang[i*4 +: 4] = m_la[i][3:0];
      e_typ[i*4 +: 4] = m_lt[i][3:0];
    end
    check({tag, "_valid"}, 64'(out_valid), 64'(valid));
    check({tag, "_in_pixel"}, 64'(in_pixel), 64'(e_in));
    check({tag, "_loc_hc"}, 64'(loc_hc), 64'(e_lhc));
    check({tag, "_loc_vc"}, 64'(loc_vc), 64'(e_lvc));
    check({tag, "_active"}, 64'(active), 64'(e_act));
    check({tag, "_angle"}, 64'(angle), 64'(e_ang));
    check({tag, "_etype"}, 64'(etype), 64'(e_typ));
  endtask

  task automatic check_pixel(input string tag, input int h, input int v, input bit valid);
    hc = h[9:0]; vc = v[9:0]; pix_valid = valid;
    @(posedge CLK); #1;
    pix_valid = 1'b0;
    @(posedge CLK); #1;
    check_outputs(tag, h, v, valid);
  endtask

  initial begin
    model_clear();

    // Reset state
    #3;
    check("rst_ready", 64'(wr_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    @(negedge CLK); RST_N = 1'b1;
    #1 check("release_ready_pre", 64'(wr_ready), 64'd0);
    @(posedge CLK); #1;
    check("release_ready", 64'(wr_ready), 64'd1);

    // First hit, including fixed expectations from hand arithmetic
    do_write(2, 100, 50, 5, 3, 1, 1'b0);
    do_commit();
    check_pixel("tp1", 110, 60, 1'b1);
    check("tp1_in_const", 64'(in_pixel), 64'b000100);
    check("tp1_lhc_const", 64'(loc_hc[29:20]), 64'd10);
    check("tp1_lvc_const", 64'(loc_vc[29:20]), 64'd10);

    // Bounding-box edges
    check_pixel("edge_in", 135, 85, 1'b1);
    check("edge_in_lhc", 64'(loc_hc[29:20]), 64'd35);
    check_pixel("edge_out_right", 136, 85, 1'b1);
    check_pixel("edge_out_left", 99, 60, 1'b1);
    check_pixel("no_valid", 110, 60, 1'b0);

    // Shadow write invisible until commit
    do_write(0, 300, 200, 9, 7, 1, 1'b0);
    check_pixel("shadow_hidden", 305, 205, 1'b1);
    do_commit();
    check_pixel("shadow_live", 305, 205, 1'b1);

    // Write coincident with frame_start
    do_write(3, 700, 400, 2, 12, 1, 1'b1);
    check_pixel("fs_write", 710, 410, 1'b1);

    // Invalid slot dropped; repeated slot last write wins
    do_write(7, 110, 60, 15, 15, 1, 1'b0);
    do_commit();
    check_pixel("bad_slot", 110, 60, 1'b1);
    do_write(1, 500, 300, 1, 1, 1, 1'b0);
    do_write(1, 600, 300, 4, 6, 1, 1'b0);
    do_commit();
    check_pixel("last_wins_hit", 605, 310, 1'b1);
    check_pixel("last_wins_old", 505, 310, 1'b1);

    // Screen corner: clipped, no wrap into column/row 0
    do_write(4, 1010, 1000, 8, 8, 1, 1'b0);
    do_commit();
    check_pixel("corner_hit", 1023, 1023, 1'b1);
    check_pixel("corner_nowrap", 5, 1005, 1'b1);

    // Randomised traffic
    repeat (150) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        int x, y;
        x = $urandom_range(0, 1) ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 1023));
        y = $urandom_range(0, 1) ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 1023));
        do_write(int'($urandom_range(0, 7)), x, y, int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0) ? 1 : 0,
                 $urandom_range(0, 3) == 0);
      end else if (sel == 1) begin
        do_commit();
      end else begin
        int s, h, v;
        s = int'($urandom_range(0, 5));
        h = m_lx[s] + int'($urandom_range(0, 40)) - 2;
        v = m_ly[s] + int'($urandom_range(0, 40)) - 2;
        if (h < 0) h = 0;
        if (h > 1023) h = 1023;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        check_pixel("rand", h, v, $urandom_range(0, 5) != 0);
      end
    end

    // Asynchronous reset mid-frame with a hit in flight
    do_write(5, 200, 200, 3, 3, 1, 1'b0);
    do_commit();
    hc = 10'd210; vc = 10'd210; pix_valid = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_outputs("pre_reset", 210, 210, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_pixel", 64'(in_pixel), 64'd0);
    check("async_active", 64'(active), 64'd0);
    check("async_ready", 64'(wr_ready), 64'd0);
    pix_valid = 1'b0;
    model_clear();
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rerelease_ready", 64'(wr_ready), 64'd1);
    check_pixel("post_reset", 210, 210, 1'b1);
    do_commit();
    check_pixel("post_reset_commit", 210, 210, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
